// File: rtl/prim_calc_pkg.sv
// Shared types and hex-to-segment decoding for the multi-digit rotary calculator.
package prim_calc_pkg;

    typedef enum logic [1:0] {
        StEnterA  = 2'd0,
        StEnterOp = 2'd1,
        StEnterB  = 2'd2,
        StShow    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpMax = 2'd3
    } op_e;

    // Segments g..a on bits 6..0, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/rotary_step_decoder.sv
// Synchronises and debounces the encoder phases and buttons, and turns the
// debounced levels into single-cycle step/press pulses.
module rotary_step_decoder #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic select,
    input  logic restart,
    input  logic rotary_a,
    input  logic rotary_b,
    output logic step_up,
    output logic step_dn,
    output logic select_p,
    output logic restart_p
);

    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    // Bit order: 0 = A, 1 = B, 2 = select, 3 = restart.
    logic [3:0] pad;
    logic [3:0] sync1_q, sync2_q, deb_q, deb_dly_q, rise;
    logic [CntW-1:0] cnt_q [4];

    assign pad = {restart, select, rotary_b, rotary_a};

    // Counter tracks how long the synchronised sample has disagreed with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= pad;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise      = deb_q & ~deb_dly_q;
    assign step_up   = rise[0] & ~deb_q[1];
    assign step_dn   = rise[0] & deb_q[1];
    assign select_p  = rise[2];
    assign restart_p = rise[3];

endmodule

// File: rtl/prim_calc_multi.sv
// Rotary-encoder calculator: operand/operator entry FSM, WIDTH-bit ALU and a
// time-multiplexed DIGITS-digit hex seven-segment scan driver.
module prim_calc_multi
    import prim_calc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              restart,
    input  logic              rotary_a,
    input  logic              rotary_b,
    output logic [6:0]        seven_segment_out,
    output logic [DIGITS-1:0] seven_segment_digit,
    output logic              led_flag,
    output logic              sync,
    output logic [8+DIGITS:0] io_oeb
);

    localparam int unsigned DispW = 4 * DIGITS;
    localparam int unsigned ScanW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DIGITS - 1);

    logic step_up, step_dn, select_p, restart_p;

    rotary_step_decoder #(
        .DEBOUNCE(DEBOUNCE)
    ) u_decoder (
        .clk      (clk),
        .rst      (rst),
        .select   (select),
        .restart  (restart),
        .rotary_a (rotary_a),
        .rotary_b (rotary_b),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .select_p (select_p),
        .restart_p(restart_p)
    );

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 flag_q, flag_d;

    // ALU; narrow intermediates keep SUB/MAX from being widened before the operation.
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff, larger;
    logic [2*WIDTH-1:0]   prod, alu_res;
    logic                 alu_flag;

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign diff   = a_q - b_q;
    assign larger = (a_q > b_q) ? a_q : b_q;
    assign prod   = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        unique case (op_q)
            OpAdd: begin alu_res = (2*WIDTH)'(sum);    alu_flag = sum[WIDTH];           end
            OpSub: begin alu_res = (2*WIDTH)'(diff);   alu_flag = a_q < b_q;            end
            OpMul: begin alu_res = prod;               alu_flag = |prod[2*WIDTH-1:WIDTH]; end
            OpMax: begin alu_res = (2*WIDTH)'(larger); alu_flag = 1'b0;                 end
        endcase
    end

    // Priority: restart, then select, then a step on the current field.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flag_d  = flag_q;
        if (restart_p) begin
            state_d = StEnterA;
            a_d     = '0;
            b_d     = '0;
            op_d    = OpAdd;
            res_d   = '0;
            flag_d  = 1'b0;
        end else if (select_p) begin
            unique case (state_q)
                StEnterA:  state_d = StEnterOp;
                StEnterOp: state_d = StEnterB;
                StEnterB: begin
                    state_d = StShow;
                    res_d   = alu_res;
                    flag_d  = alu_flag;
                end
                StShow:    state_d = StEnterA;
            endcase
        end else if (step_up || step_dn) begin
            unique case (state_q)
                StEnterA:  a_d  = step_up ? a_q + 1'b1 : a_q - 1'b1;
                StEnterOp: op_d = op_e'(step_up ? op_q + 2'd1 : op_q - 2'd1);
                StEnterB:  b_d  = step_up ? b_q + 1'b1 : b_q - 1'b1;
                StShow:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEnterA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OpAdd;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    logic [DispW-1:0] disp_val;

    always_comb begin
        disp_val = '0;
        unique case (state_q)
            StEnterA:  disp_val = DispW'(a_q);
            StEnterOp: disp_val = DispW'(op_q);
            StEnterB:  disp_val = DispW'(b_q);
            StShow:    disp_val = DispW'(res_q);
        endcase
    end

    logic [ScanW-1:0]  scan_cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_q;
    logic              sync_q;

    // Each wrap latches the digit at idx_q, then moves the index on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            dig_q      <= '0;
            sync_q     <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            if (scan_cnt_q == ScanMax) begin
                scan_cnt_q <= '0;
                seg_q      <= hex_to_seg(disp_val[idx_q*4 +: 4]);
                dig_q      <= DIGITS'(1) << idx_q;
                sync_q     <= (idx_q == '0);
                idx_q      <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
        end
    end

    assign seven_segment_out   = seg_q;
    assign seven_segment_digit = dig_q;
    assign led_flag            = flag_q;
    assign sync                = sync_q;
    assign io_oeb              = '0;

endmodule
